// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and reset cause codes.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_INIT      = 2'd1,
        S_STAGE     = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Counts consecutive pll_locked cycles; lock_ok is a registered level for the sequencer FSM.
module lock_filter #(
    parameter int LOCK_FILTER = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic pll_locked,
    output logic lock_ok
);

    localparam int CW = $clog2(LOCK_FILTER + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (clr || !pll_locked) begin
            cnt_next = '0;
        end else if (cnt < CW'(LOCK_FILTER)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // lock_ok flags LOCK_FILTER-1 locked cycles already seen, so the FSM can qualify
    // lock on the very edge that supplies the final consecutive locked sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            lock_ok <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            lock_ok <= (cnt_next >= CW'(LOCK_FILTER - 1));
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: qualifies PLL lock, holds resets, then releases NUM_CH channels in order.
module reset_sequencer #(
    parameter int NUM_CH       = 3,
    parameter int INIT_CYCLES  = 32768,
    parameter int STAGE_CYCLES = 256,
    parameter int LOCK_FILTER  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              sw_reset_req,
    output logic [NUM_CH-1:0] reset_out,
    output logic              seq_done,
    output logic              lock_lost,
    output logic [1:0]        reset_cause
);
    import reset_sequencer_pkg::*;

    localparam int MAIN_W = $clog2(max_int(INIT_CYCLES, STAGE_CYCLES) + 1);
    localparam int IDX_W  = $clog2(NUM_CH) + 1;
    localparam logic [MAIN_W-1:0] INIT_LAST  = MAIN_W'(INIT_CYCLES - 1);
    localparam logic [MAIN_W-1:0] STAGE_LAST = MAIN_W'(STAGE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_CH - 1);

    state_t            state, state_next;
    logic [MAIN_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [NUM_CH-1:0] rst_q, rst_next;
    logic              done_q, done_next;
    logic              lost_q, lost_next;
    logic [1:0]        cause_q, cause_next;
    logic              filter_clr;
    logic              lock_ok;

    assign filter_clr = (state != S_WAIT_LOCK);

    lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (filter_clr),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        rst_next   = rst_q;
        done_next  = done_q;
        lost_next  = 1'b0;
        cause_next = cause_q;
        case (state)
            S_WAIT_LOCK: begin
                rst_next  = '1;
                done_next = 1'b0;
                cnt_next  = '0;
                idx_next  = '0;
                if (lock_ok && pll_locked) begin
                    state_next = S_INIT;
                end
            end
            S_INIT, S_STAGE, S_RUN: begin
                if (!pll_locked) begin
                    state_next = S_WAIT_LOCK;
                    rst_next   = '1;
                    done_next  = 1'b0;
                    lost_next  = 1'b1;
                    cause_next = CAUSE_LOCK;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else if (sw_reset_req) begin
                    state_next = S_INIT;
                    rst_next   = '1;
                    done_next  = 1'b0;
                    cause_next = CAUSE_SW;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else if (state == S_INIT) begin
                    if (cnt >= INIT_LAST) begin
                        // Channels release in index order, so a left shift drops the next one.
                        cnt_next = '0;
                        rst_next = rst_q << 1;
                        idx_next = IDX_W'(1);
                        if (NUM_CH == 1) begin
                            state_next = S_RUN;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_STAGE;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else if (state == S_STAGE) begin
                    if (cnt >= STAGE_LAST) begin
                        cnt_next = '0;
                        rst_next = rst_q << 1;
                        if (idx >= IDX_LAST) begin
                            state_next = S_RUN;
                            done_next  = 1'b1;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    rst_next  = '0;
                    done_next = 1'b1;
                end
            end
            default: begin
                state_next = S_WAIT_LOCK;
                rst_next   = '1;
                done_next  = 1'b0;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            rst_q   <= rst_next;
            done_q  <= done_next;
            lost_q  <= lost_next;
            cause_q <= cause_next;
        end
    end

    assign reset_out   = rst_q;
    assign seq_done    = done_q;
    assign lock_lost   = lost_q;
    assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed vector table, corner sequences, random run vs timing model.
module tb_reset_sequencer;

    localparam int NUM_CH       = 3;
    localparam int INIT_CYCLES  = 16;
    localparam int STAGE_CYCLES = 4;
    localparam int LOCK_FILTER  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pll_locked = 1'b0;
    logic              sw_reset_req = 1'b0;
    logic [NUM_CH-1:0] reset_out;
    logic              seq_done;
    logic              lock_lost;
    logic [1:0]        reset_cause;

    int checks = 0;
    int errors = 0;

    // Reference model: lock-run length, time the hold interval began, sticky cause.
    int       cyc = 0;
    int       run = 0;
    int       t0 = 0;
    bit       in_init = 1'b0;
    bit       m_lost = 1'b0;
    logic [1:0] m_cause = 2'b00;

    typedef struct {
        logic       r;
        logic       l;
        logic       s;
        int         n;
        logic [2:0] rst;
        logic       done;
        logic       lost;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_CH       (NUM_CH),
        .INIT_CYCLES  (INIT_CYCLES),
        .STAGE_CYCLES (STAGE_CYCLES),
        .LOCK_FILTER  (LOCK_FILTER)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .reset_out    (reset_out),
        .seq_done     (seq_done),
        .lock_lost    (lock_lost),
        .reset_cause  (reset_cause)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_reset();
        logic [NUM_CH-1:0] v;
        v = '1;
        if (in_init) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cyc - t0 >= INIT_CYCLES + k * STAGE_CYCLES) v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    function automatic logic exp_done();
        return in_init && (cyc - t0 >= INIT_CYCLES + (NUM_CH - 1) * STAGE_CYCLES);
    endfunction

    task automatic model_edge();
        m_lost = 1'b0;
        if (!rst_n) begin
            in_init = 1'b0;
            run     = 0;
            m_cause = 2'b00;
        end else if (!in_init) begin
            run = pll_locked ? run + 1 : 0;
            if (run >= LOCK_FILTER) begin
                in_init = 1'b1;
                t0      = cyc;
                run     = 0;
            end
        end else if (!pll_locked) begin
            in_init = 1'b0;
            run     = 0;
            m_lost  = 1'b1;
            m_cause = 2'b01;
        end else if (sw_reset_req) begin
            t0      = cyc;
            m_cause = 2'b10;
        end
    endtask

    task automatic step(input logic r, input logic l, input logic s);
        rst_n        = r;
        pll_locked   = l;
        sw_reset_req = s;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check("model reset_out", 32'(reset_out), 32'(exp_reset()));
        check("model seq_done", 32'(seq_done), 32'(exp_done()));
        check("model lock_lost", 32'(lock_lost), 32'(m_lost));
        check("model reset_cause", 32'(reset_cause), 32'(m_cause));
    endtask

    task automatic add(input logic r, input logic l, input logic s, input int n,
                       input logic [2:0] rst, input logic done, input logic lost, input logic [1:0] cause);
        vec_t v;
        v.r = r; v.l = l; v.s = s; v.n = n;
        v.rst = rst; v.done = done; v.lost = lost; v.cause = cause;
        vecs.push_back(v);
    endtask

    initial begin
        // Power-up sequence: lock after 8, releases at +24, +28, +32 from reset release.
        add(0, 0, 0, 5,  3'b111, 0, 0, 2'b00);
        add(1, 1, 0, 8,  3'b111, 0, 0, 2'b00);
        add(1, 1, 0, 15, 3'b111, 0, 0, 2'b00);
        add(1, 1, 0, 1,  3'b110, 0, 0, 2'b00);
        add(1, 1, 0, 4,  3'b100, 0, 0, 2'b00);
        add(1, 1, 0, 3,  3'b100, 0, 0, 2'b00);
        add(1, 1, 0, 1,  3'b000, 1, 0, 2'b00);
        add(1, 1, 0, 5,  3'b000, 1, 0, 2'b00);
        // Lock loss in S_RUN, then full re-sequence.
        add(1, 0, 0, 1,  3'b111, 0, 1, 2'b01);
        add(1, 1, 0, 1,  3'b111, 0, 0, 2'b01);
        add(1, 1, 0, 22, 3'b111, 0, 0, 2'b01);
        add(1, 1, 0, 1,  3'b110, 0, 0, 2'b01);
        add(1, 1, 0, 4,  3'b100, 0, 0, 2'b01);
        add(1, 1, 0, 4,  3'b000, 1, 0, 2'b01);
        // Software pulse in S_RUN: no filter wait.
        add(1, 1, 1, 1,  3'b111, 0, 0, 2'b10);
        add(1, 1, 0, 15, 3'b111, 0, 0, 2'b10);
        add(1, 1, 0, 1,  3'b110, 0, 0, 2'b10);
        add(1, 1, 0, 4,  3'b100, 0, 0, 2'b10);
        // Lock loss beats software request in S_STAGE.
        add(1, 0, 1, 1,  3'b111, 0, 1, 2'b01);
        // Filter restart: 5 high, 1 low, then 8 consecutive needed.
        add(1, 1, 0, 5,  3'b111, 0, 0, 2'b01);
        add(1, 0, 0, 1,  3'b111, 0, 0, 2'b01);
        add(1, 1, 0, 7,  3'b111, 0, 0, 2'b01);
        add(1, 1, 0, 16, 3'b111, 0, 0, 2'b01);
        add(1, 1, 0, 1,  3'b110, 0, 0, 2'b01);
        add(1, 1, 0, 4,  3'b100, 0, 0, 2'b01);
        // rst_n mid-S_STAGE.
        add(0, 1, 0, 1,  3'b111, 0, 0, 2'b00);

        foreach (vecs[i]) begin
            repeat (vecs[i].n) step(vecs[i].r, vecs[i].l, vecs[i].s);
            check($sformatf("vec%0d reset_out", i), 32'(reset_out), 32'(vecs[i].rst));
            check($sformatf("vec%0d seq_done", i), 32'(seq_done), 32'(vecs[i].done));
            check($sformatf("vec%0d lock_lost", i), 32'(lock_lost), 32'(vecs[i].lost));
            check($sformatf("vec%0d reset_cause", i), 32'(reset_cause), 32'(vecs[i].cause));
        end

        // sw_reset_req during lock qualification is ignored.
        repeat (2) step(0, 1, 0);
        repeat (5) step(1, 1, 1);
        repeat (19) step(1, 1, 0);
        check("sw ignored reset_out", 32'(reset_out), 32'(3'b110));
        check("sw ignored cause", 32'(reset_cause), 32'(2'b00));
        repeat (8) step(1, 1, 0);
        check("sw ignored seq_done", 32'(seq_done), 32'(1'b1));

        // Held sw level keeps restarting; release counts from the last high sample.
        repeat (10) step(1, 1, 1);
        check("sw level reset_out", 32'(reset_out), 32'(3'b111));
        check("sw level cause", 32'(reset_cause), 32'(2'b10));
        repeat (15) step(1, 1, 0);
        check("sw level hold", 32'(reset_out), 32'(3'b111));
        step(1, 1, 0);
        check("sw level release", 32'(reset_out), 32'(3'b110));

        // Randomized traffic against the timing model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 79) != 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
